// File: rtl/lutram_fwft_fifo_pkg.sv
// Shared helpers for the LUT-RAM FWFT FIFO: address/pointer width derivation and parameter sanity.
package lutram_fwft_fifo_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int unsigned ptrWidth(input int unsigned addrWidth);
    return addrWidth + 1;
  endfunction

  function automatic bit paramsOk(input int unsigned depth,
                                  input int unsigned addrWidth,
                                  input int unsigned almostFull);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (addrWidth == clog2(depth)) && (almostFull <= depth);
  endfunction

endpackage

// File: rtl/lutram_fwft_fifo_lut_ram_dp.sv
// Distributed dual-port storage: registered write port, asynchronous read port.
module lut_ram_dp
  import lutram_fwft_fifo_pkg::*;
#(
  parameter int unsigned pDepth = 16,
  parameter int unsigned pWidth = 8,
  parameter int unsigned pAddrW = clog2(pDepth)
) (
  input  logic              iCLK,
  input  logic [pWidth-1:0] iWD,
  input  logic [pAddrW-1:0] iWA,
  input  logic              iWE,
  input  logic [pAddrW-1:0] iRA,
  output logic [pWidth-1:0] oRD
);

  logic [pWidth-1:0] mem [pDepth];

  always_ff @(posedge iCLK) begin
    if (iWE) mem[iWA] <= iWD;
  end

  assign oRD = mem[iRA];

endmodule

// File: rtl/lutram_fwft_fifo.sv
// First-word-fall-through FIFO over LUT RAM with fill level and registered flags.
// Optional sticky overflow/underflow outputs when LUTFIFO_ERR_FLAG_EN is defined.
module lutram_fwft_fifo
  import lutram_fwft_fifo_pkg::*;
#(
  parameter int unsigned pBuffDepth   = 16,
  parameter int unsigned pBitWidth    = 8,
  parameter int unsigned pAddrWidth   = 4,
  parameter int unsigned pAlmostFull  = 12,
  parameter int unsigned pAlmostEmpty = 2
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [pBitWidth-1:0] iWD,
  input  logic                 iWE,
  output logic                 oFLL,
  output logic                 oAFL,
  input  logic                 iRE,
  output logic [pBitWidth-1:0] oRD,
  output logic                 oEMP,
  output logic                 oAEP,
  output logic [pAddrWidth:0]  oCNT
`ifdef LUTFIFO_ERR_FLAG_EN
  ,
  output logic                 oOVF,
  output logic                 oUDF
`endif
);

  localparam int unsigned pPtrWidth = ptrWidth(pAddrWidth);

  if (!paramsOk(pBuffDepth, pAddrWidth, pAlmostFull)) begin : gBadParams
    $error("lutram_fwft_fifo: inconsistent depth/address/threshold parameters");
  end

  logic [pPtrWidth-1:0] wPtr, rPtr;
  logic [pPtrWidth-1:0] wPtrNxt, rPtrNxt, cntNxt;
  logic                 wrOk, rdOk;
  logic                 empNxt, fllNxt, aflNxt, aepNxt;

  // Accept rules; flags are registered, so there is no path from iWE/iRE to them.
  always_comb begin
    wrOk    = iWE & ~oFLL;
    rdOk    = iRE & ~oEMP;
    wPtrNxt = wPtr + pPtrWidth'(wrOk);
    rPtrNxt = rPtr + pPtrWidth'(rdOk);
    cntNxt  = oCNT + pPtrWidth'(wrOk) - pPtrWidth'(rdOk);
    empNxt  = (wPtrNxt == rPtrNxt);
    fllNxt  = (wPtrNxt[pAddrWidth-1:0] == rPtrNxt[pAddrWidth-1:0]) &&
              (wPtrNxt[pAddrWidth] != rPtrNxt[pAddrWidth]);
    aflNxt  = (cntNxt >= pPtrWidth'(pAlmostFull));
    aepNxt  = (cntNxt <= pPtrWidth'(pAlmostEmpty));
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wPtr <= '0;
      rPtr <= '0;
      oCNT <= '0;
      oEMP <= 1'b1;
      oFLL <= 1'b0;
      oAFL <= 1'b0;
      oAEP <= 1'b1;
    end else begin
      wPtr <= wPtrNxt;
      rPtr <= rPtrNxt;
      oCNT <= cntNxt;
      oEMP <= empNxt;
      oFLL <= fllNxt;
      oAFL <= aflNxt;
      oAEP <= aepNxt;
    end
  end

`ifdef LUTFIFO_ERR_FLAG_EN
  // Sticky record of any dropped request since the last reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oOVF <= 1'b0;
      oUDF <= 1'b0;
    end else begin
      if (iWE & oFLL) oOVF <= 1'b1;
      if (iRE & oEMP) oUDF <= 1'b1;
    end
  end
`endif

  lut_ram_dp #(
    .pDepth(pBuffDepth),
    .pWidth(pBitWidth),
    .pAddrW(pAddrWidth)
  ) uRam (
    .iCLK (iCLK),
    .iWD  (iWD),
    .iWA  (wPtr[pAddrWidth-1:0]),
    .iWE  (wrOk & ~iRST),
    .iRA  (rPtr[pAddrWidth-1:0]),
    .oRD  (oRD)
  );

endmodule

// File: tb/tb_lutram_fwft_fifo.sv
// Self-checking bench for lutram_fwft_fifo against a queue-based reference model.
module tb_lutram_fwft_fifo;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int AEMPTY = 2;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic [7:0] iWD  = '0;
  logic       iWE  = 1'b0;
  logic       iRE  = 1'b0;
  logic       oFLL, oAFL, oEMP, oAEP;
  logic [7:0] oRD;
  logic [4:0] oCNT;
`ifdef LUTFIFO_ERR_FLAG_EN
  logic       oOVF, oUDF;
`endif

  lutram_fwft_fifo dut (
    .iCLK(iCLK), .iRST(iRST), .iWD(iWD), .iWE(iWE), .oFLL(oFLL), .oAFL(oAFL),
    .iRE(iRE), .oRD(oRD), .oEMP(oEMP), .oAEP(oAEP), .oCNT(oCNT)
`ifdef LUTFIFO_ERR_FLAG_EN
    , .oOVF(oOVF), .oUDF(oUDF)
`endif
  );

  always #5 iCLK = ~iCLK;

  logic [7:0] q[$];
  bit         mOvf, mUdf;
  int         nCmp = 0;
  int         nErr = 0;

  // Drive one clock of requests and advance the reference model.
  task automatic cycle(input logic we, input logic re, input logic [7:0] wd);
    bit wrAcc, rdAcc;
    iWE = we; iRE = re; iWD = wd;
    @(posedge iCLK);
    wrAcc = we && (q.size() < DEPTH);
    rdAcc = re && (q.size() > 0);
    if (we && q.size() == DEPTH) mOvf = 1'b1;
    if (re && q.size() == 0) mUdf = 1'b1;
    if (rdAcc) void'(q.pop_front());
    if (wrAcc) q.push_back(wd);
    #1;
    iWE = 1'b0; iRE = 1'b0;
  endtask

  task automatic doReset(input logic we, input logic [7:0] wd);
    iRST = 1'b1; iWE = we; iRE = 1'b1; iWD = wd;
    @(posedge iCLK);
    q.delete(); mOvf = 1'b0; mUdf = 1'b0;
    #1;
    iRST = 1'b0; iWE = 1'b0; iRE = 1'b0;
  endtask

  task automatic test_reset();
    doReset(1'b0, 8'h00);
    nCmp++; if (oCNT !== 5'd0) begin nErr++; $display("FAIL reset_cnt got %0d want 0", oCNT); end
    nCmp++; if (oEMP !== 1'b1) begin nErr++; $display("FAIL reset_emp got %b want 1", oEMP); end
    nCmp++; if (oFLL !== 1'b0) begin nErr++; $display("FAIL reset_fll got %b want 0", oFLL); end
    nCmp++; if (oAFL !== 1'b0) begin nErr++; $display("FAIL reset_afl got %b want 0", oAFL); end
    nCmp++; if (oAEP !== 1'b1) begin nErr++; $display("FAIL reset_aep got %b want 1", oAEP); end
`ifdef LUTFIFO_ERR_FLAG_EN
    nCmp++; if ({oOVF, oUDF} !== 2'b00) begin nErr++; $display("FAIL reset_err got %b%b want 00", oOVF, oUDF); end
`endif
  endtask

  task automatic test_basic();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, vals[i]);
      nCmp++; if (oCNT !== 5'(i + 1)) begin nErr++; $display("FAIL basic_wr_cnt got %0d want %0d", oCNT, i + 1); end
      nCmp++; if (oEMP !== 1'b0) begin nErr++; $display("FAIL basic_emp got %b want 0", oEMP); end
    end
    for (int i = 0; i < 3; i++) begin
      nCmp++; if (oRD !== vals[i]) begin nErr++; $display("FAIL basic_rd got %h want %h", oRD, vals[i]); end
      cycle(1'b0, 1'b1, 8'h00);
      nCmp++; if (oCNT !== 5'(2 - i)) begin nErr++; $display("FAIL basic_rd_cnt got %0d want %0d", oCNT, 2 - i); end
    end
    nCmp++; if (oEMP !== 1'b1) begin nErr++; $display("FAIL basic_end_emp got %b want 1", oEMP); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      nCmp++; if (oCNT !== 5'(i + 1)) begin nErr++; $display("FAIL fill_cnt got %0d want %0d", oCNT, i + 1); end
      nCmp++; if (oAFL !== (i + 1 >= AFULL)) begin nErr++; $display("FAIL fill_afl at %0d got %b", i + 1, oAFL); end
      nCmp++; if (oFLL !== (i + 1 == DEPTH)) begin nErr++; $display("FAIL fill_fll at %0d got %b", i + 1, oFLL); end
      nCmp++; if (oAEP !== (i + 1 <= AEMPTY)) begin nErr++; $display("FAIL fill_aep at %0d got %b", i + 1, oAEP); end
    end
    cycle(1'b1, 1'b0, 8'hAA);
    nCmp++; if (oCNT !== 5'd16) begin nErr++; $display("FAIL fill_drop_cnt got %0d want 16", oCNT); end
`ifdef LUTFIFO_ERR_FLAG_EN
    nCmp++; if (oOVF !== 1'b1) begin nErr++; $display("FAIL fill_ovf got %b want 1", oOVF); end
    nCmp++; if (oUDF !== 1'b0) begin nErr++; $display("FAIL fill_udf got %b want 0", oUDF); end
`endif
    for (int i = 0; i < DEPTH; i++) begin
      nCmp++; if (oRD !== 8'(i)) begin nErr++; $display("FAIL fill_pop got %h want %h", oRD, 8'(i)); end
      cycle(1'b0, 1'b1, 8'h00);
    end
    nCmp++; if (oEMP !== 1'b1 || oCNT !== 5'd0) begin nErr++; $display("FAIL fill_empty got emp=%b cnt=%0d want 1/0", oEMP, oCNT); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(i));
    cycle(1'b1, 1'b1, 8'h55);
    nCmp++; if (oCNT !== 5'd15) begin nErr++; $display("FAIL fullrw_cnt got %0d want 15", oCNT); end
    nCmp++; if (oFLL !== 1'b0) begin nErr++; $display("FAIL fullrw_fll got %b want 0", oFLL); end
    for (int i = 1; i < DEPTH; i++) begin
      nCmp++; if (oRD !== 8'(i)) begin nErr++; $display("FAIL fullrw_pop got %h want %h", oRD, 8'(i)); end
      cycle(1'b0, 1'b1, 8'h00);
    end
    nCmp++; if (oEMP !== 1'b1) begin nErr++; $display("FAIL fullrw_empty got %b want 1", oEMP); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat;
    pat = 8'h80;
    for (int i = 0; i < 8; i++) begin cycle(1'b1, 1'b0, pat); pat++; end
    for (int i = 0; i < 40; i++) begin
      nCmp++; if (oRD !== q[0]) begin nErr++; $display("FAIL b2b_rd got %h want %h", oRD, q[0]); end
      cycle(1'b1, 1'b1, pat); pat++;
      nCmp++; if (oCNT !== 5'd8) begin nErr++; $display("FAIL b2b_cnt got %0d want 8", oCNT); end
      nCmp++; if ({oEMP, oFLL, oAFL, oAEP} !== 4'b0000) begin nErr++; $display("FAIL b2b_flags got %b want 0000", {oEMP, oFLL, oAFL, oAEP}); end
    end
    for (int i = 0; i < 8; i++) begin
      nCmp++; if (oRD !== 8'(8'h80 + 40 + i)) begin nErr++; $display("FAIL b2b_drain got %h want %h", oRD, 8'(8'h80 + 40 + i)); end
      cycle(1'b0, 1'b1, 8'h00);
    end
  endtask

  task automatic test_empty_rw();
    doReset(1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h77);
    nCmp++; if (oCNT !== 5'd1) begin nErr++; $display("FAIL emptyrw_cnt got %0d want 1", oCNT); end
    nCmp++; if (oRD !== 8'h77 || oEMP !== 1'b0) begin nErr++; $display("FAIL emptyrw_rd got %h emp=%b want 77/0", oRD, oEMP); end
`ifdef LUTFIFO_ERR_FLAG_EN
    nCmp++; if (oUDF !== 1'b1) begin nErr++; $display("FAIL emptyrw_udf got %b want 1", oUDF); end
`endif
  endtask

  task automatic test_reset_mid();
    while (q.size() < 10) cycle(1'b1, 1'b0, 8'($urandom));
    nCmp++; if (oCNT !== 5'd10) begin nErr++; $display("FAIL rstmid_pre got %0d want 10", oCNT); end
    doReset(1'b1, 8'hEE);
    nCmp++; if ({oEMP, oAEP, oAFL, oFLL} !== 4'b1100 || oCNT !== 5'd0) begin
      nErr++; $display("FAIL rstmid_state got emp/aep/afl/fll=%b cnt=%0d want 1100/0", {oEMP, oAEP, oAFL, oFLL}, oCNT);
    end
    cycle(1'b0, 1'b1, 8'h00);
    nCmp++; if (oCNT !== 5'd0 || oEMP !== 1'b1) begin nErr++; $display("FAIL rstmid_notstored got cnt=%0d emp=%b want 0/1", oCNT, oEMP); end
    cycle(1'b1, 1'b0, 8'h5A);
    nCmp++; if (oRD !== 8'h5A || oCNT !== 5'd1) begin nErr++; $display("FAIL rstmid_after got %h cnt=%0d want 5a/1", oRD, oCNT); end
  endtask

  task automatic test_random();
    int bias;
    for (int i = 0; i < 600; i++) begin
      bias = (i / 100) % 2 == 0 ? 70 : 30;
      if ($urandom_range(199) == 0) doReset($urandom_range(1), 8'($urandom));
      else cycle($urandom_range(99) < bias, $urandom_range(99) >= bias - 20, 8'($urandom));
      nCmp++;
      if (oCNT !== 5'(q.size()) || oEMP !== (q.size() == 0) || oFLL !== (q.size() == DEPTH) ||
          oAFL !== (q.size() >= AFULL) || oAEP !== (q.size() <= AEMPTY)) begin
        nErr++;
        $display("FAIL rand_state cyc %0d got cnt=%0d e/f/af/ae=%b%b%b%b want cnt=%0d", i, oCNT, oEMP, oFLL, oAFL, oAEP, q.size());
      end
      if (q.size() > 0) begin
        nCmp++; if (oRD !== q[0]) begin nErr++; $display("FAIL rand_rd cyc %0d got %h want %h", i, oRD, q[0]); end
      end
`ifdef LUTFIFO_ERR_FLAG_EN
      nCmp++; if (oOVF !== mOvf || oUDF !== mUdf) begin nErr++; $display("FAIL rand_err got %b%b want %b%b", oOVF, oUDF, mOvf, mUdf); end
`endif
    end
  endtask

  initial begin
    repeat (2) @(posedge iCLK);
    #1;
    test_reset();
    test_basic();
    test_fill();
    test_full_rw();
    test_back_to_back();
    test_empty_rw();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/lutram_fwft_fifo.md
Name: lutram_fwft_fifo

Overview:
- Synchronous first-word-fall-through FIFO built on distributed (LUT) RAM. The head word is always visible on oRD with zero read latency.
- Adds what the bare LUT RAM lacks: pointer management, full/empty and almost-full/almost-empty flags, fill level, and protected accept/pop rules.
- Used as the generic small buffer between single-clock producers and consumers, e.g. MIDI byte streams and command queues.

Parameters:
- pBuffDepth, 16, number of words; must be a power of two, minimum 4.
- pBitWidth, 8, data word width.
- pAddrWidth, 4, log2(pBuffDepth); RAM address width.
- pAlmostFull, 12, oAFL asserts when level >= this value.
- pAlmostEmpty, 2, oAEP asserts when level <= this value.

Ports:
- iCLK  in  1  sole clock; all state updates on its rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iWD  in  pBitWidth  write data.
- iWE  in  1  write request.
- oFLL  out  1  full.
- oAFL  out  1  almost full.
- iRE  in  1  read/pop request; acknowledges the word currently on oRD.
- oRD  out  pBitWidth  head word, combinational from RAM.
- oEMP  out  1  empty; oRD is don't-care while high.
- oAEP  out  1  almost empty.
- oCNT  out  pAddrWidth+1  current fill level, 0..pBuffDepth.

Behaviour:
- Clocking and reset: one clock, iCLK. Reset iRST is synchronous and active-high.
- Reset values: write pointer = 0, read pointer = 0, oCNT = 0, oEMP = 1, oFLL = 0, oAFL = 0, oAEP = 1. RAM contents are not cleared.
- Reset mid-operation: all stored words are discarded on the reset edge. The iWE/iRE requests sampled on that edge are ignored.
- Pointers are pAddrWidth+1 bits. The extra MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - Pointers wrap naturally modulo 2*pBuffDepth.
- Write accept: wr_ok = iWE & ~oFLL.
  - On the edge, RAM[wptr low bits] <= iWD and wptr increments.
  - A write while full is dropped, even if iRE is also high in the same cycle.
- Read accept: rd_ok = iRE & ~oEMP. On the edge, rptr increments.
  - A read while empty is ignored.
  - A write into an empty FIFO is visible on oRD in the next cycle, when oEMP = 0. Empty-to-data latency is 1 cycle.
- Simultaneous write and read:
  - Both accepted: oCNT is unchanged and the flags hold.
  - Write into empty FIFO with iRE high: write accepted, read ignored, oCNT becomes 1.
  - Read from full FIFO with iWE high: read accepted, write dropped, oCNT becomes pBuffDepth-1.
- oCNT update: oCNT <= oCNT + wr_ok - rd_ok. It never exceeds pBuffDepth and never underflows.
- All flags (oFLL, oEMP, oAFL, oAEP) are registered and computed from the next-state count/pointers, so they are valid in the same cycle oCNT changes. They have no combinational path from iWE/iRE.
- oRD = RAM[rptr low bits], an asynchronous read. A write to the head address of a non-empty FIFO is impossible, so there is no read-during-write hazard on the head word.

Optional Feature:
- Macro: LUTFIFO_ERR_FLAG_EN.
- With the macro: adds output oOVF (1 bit) and oUDF (1 bit).
  - oOVF is set when iWE & oFLL.
  - oUDF is set when iRE & oEMP.
  - Both flags are sticky until iRST and reset to 0.
- Without the macro: the ports are absent, and dropped requests are silent.

Decomposition:
- Shared header/package holds:
  - a clog2 constant function;
  - the pointer-width derivation (pAddrWidth+1);
  - a parameter sanity check that pAddrWidth == clog2(pBuffDepth) and pAlmostFull <= pBuffDepth.
- Sub-module: lut_ram_dp. This is a parametrised storage array with registered write port and asynchronous read port (iWD, iWA, iWE, iRA, oRD, iCLK).
- All control stays in lutram_fwft_fifo.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33 on consecutive cycles -> oEMP falls 1 cycle after the first write. oRD = 0x11, then 0x22 and 0x33 on successive pops. oCNT goes 1,2,3, then 2,1,0, and oEMP = 1 at the end.
- Write 16 words 0x00..0x0F with no reads -> oAFL rises when oCNT = 12 and oFLL rises when oCNT = 16. A 17th write of 0xAA is dropped, and popping all 16 returns 0x00..0x0F. With the macro, oOVF = 1.
- Full FIFO, iWE = iRE = 1 with iWD = 0x55 -> the pop is accepted, oCNT = 15, 0x55 is absent, and oFLL clears.
- Half-full (oCNT = 8), iWE = iRE = 1 for 40 cycles with an incrementing pattern -> oCNT holds 8, data order is preserved across pointer wrap, and the flags are stable.
- Empty FIFO, iWE = iRE = 1 with iWD = 0x77 -> oCNT = 1 and oRD = 0x77 next cycle. With the macro, oUDF = 1.
- oCNT = 10, assert iRST for 1 cycle while iWE = 1 -> oCNT = 0, oEMP = 1, oAEP = 1 and oAFL = 0 after the edge, and the write is not stored.
